adc_capture_sequencer: RTL and testbench

// - Sequences one ADC acquisition between the clk-domain frame strobe (8x12-bit frames) and the sample FIFO write port.
// - Flow: software start -> optional holdoff -> armed, waiting for a trigger -> write N frames -> done.
// - Software trigger mode, level-crossing trigger on one ADC channel, or external trigger.
// - Counts written frames and frames dropped because the FIFO was full.

---
 rtl/adc_capture_sequencer.sv | 179 +++++++++++++++++
 tb/tb_adc_capture_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_sequencer.sv
// ADC acquisition sequencer: start -> holdoff -> armed (trigger search) -> capture N frames -> done.
// Frames are forwarded to the sample FIFO with one cycle of latency; written and dropped frames are counted.
module adc_capture_sequencer #(
    parameter int FRAME_W = 96,
    parameter int CNT_W   = 32,
    parameter int HOLD_W  = 16
) (
    input  logic               clk,
    input  logic               async_resetn,
    input  logic               ctrl_start,
    input  logic               ctrl_abort,
    input  logic [CNT_W-1:0]   cfg_frame_count,
    input  logic [1:0]         cfg_trig_mode,
    input  logic [2:0]         cfg_trig_channel,
    input  logic [11:0]        cfg_trig_level,
    input  logic [HOLD_W-1:0]  cfg_holdoff,
    input  logic               ext_trig,
    input  logic               frame_valid,
    input  logic [FRAME_W-1:0] frame_data,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [FRAME_W-1:0] fifo_din,
    output logic               busy,
    output logic               irq_done,
    output logic [2:0]         state,
    output logic [CNT_W-1:0]   frames_written,
    output logic [CNT_W-1:0]   frames_dropped
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [1:0] MODE_IMMEDIATE = 2'd0;
    localparam logic [1:0] MODE_RISING    = 2'd1;
    localparam logic [1:0] MODE_FALLING   = 2'd2;
    localparam logic [1:0] MODE_EXTERNAL  = 2'd3;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q;
    logic [1:0]         trig_mode_q;
    logic [2:0]         trig_channel_q;
    logic [11:0]        trig_level_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic               prev_valid_q;
    logic [11:0]        prev_sample_q;

    logic [11:0]        cur_sample;
    logic               trigger;
    logic               last_slot;
    logic               load_cfg;
    logic               accept_frame;

    always_comb begin
        cur_sample = '0;
        for (int k = 0; k < 8; k++) begin
            if (trig_channel_q == 3'(k)) cur_sample = frame_data[12*k +: 12];
        end
    end

    // Crossing triggers need a previous sample from this arming; the first frame only primes it.
    always_comb begin
        trigger = 1'b0;
        case (trig_mode_q)
            MODE_IMMEDIATE: trigger = 1'b1;
            MODE_RISING:    trigger = prev_valid_q && (prev_sample_q < trig_level_q)
                                                   && (cur_sample >= trig_level_q);
            MODE_FALLING:   trigger = prev_valid_q && (prev_sample_q >= trig_level_q)
                                                   && (cur_sample < trig_level_q);
            MODE_EXTERNAL:  trigger = ext_trig;
            default:        trigger = 1'b0;
        endcase
    end

    // A zero remaining count means continuous capture, so it never reads as the last slot.
    assign last_slot = (remaining_q == CNT_W'(1));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        load_cfg     = 1'b0;
        accept_frame = 1'b0;
        if (ctrl_abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_start) begin
                        load_cfg = 1'b1;
                        state_d  = S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cnt_q == '0) state_d = S_ARMED;
                end
                S_ARMED: begin
                    if (frame_valid && trigger) begin
                        accept_frame = 1'b1;
                        state_d      = last_slot ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (frame_valid) begin
                        accept_frame = 1'b1;
                        if (last_slot) state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            remaining_q    <= '0;
            trig_mode_q    <= '0;
            trig_channel_q <= '0;
            trig_level_q   <= '0;
            hold_cnt_q     <= '0;
            prev_valid_q   <= 1'b0;
            prev_sample_q  <= '0;
            fifo_wr_en     <= 1'b0;
            fifo_din       <= '0;
            frames_written <= '0;
            frames_dropped <= '0;
        end else begin
            fifo_wr_en <= 1'b0;

            if (load_cfg) begin
                remaining_q    <= cfg_frame_count;
                trig_mode_q    <= cfg_trig_mode;
                trig_channel_q <= cfg_trig_channel;
                trig_level_q   <= cfg_trig_level;
                hold_cnt_q     <= cfg_holdoff;
                frames_written <= '0;
                frames_dropped <= '0;
            end

            if (state_q == S_HOLDOFF) begin
                prev_valid_q <= 1'b0;
                if (hold_cnt_q != '0) hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end

            if (state_q == S_ARMED && frame_valid && !ctrl_abort) begin
                prev_sample_q <= cur_sample;
                prev_valid_q  <= 1'b1;
            end

            // A frame dropped on fifo_full still uses up one slot of the capture.
            if (accept_frame) begin
                if (remaining_q != '0) remaining_q <= remaining_q - CNT_W'(1);
                if (!fifo_full) begin
                    fifo_wr_en <= 1'b1;
                    fifo_din   <= frame_data;
                    if (frames_written != '1) frames_written <= frames_written + CNT_W'(1);
                end else if (frames_dropped != '1) begin
                    frames_dropped <= frames_dropped + CNT_W'(1);
                end
            end
        end
    end

    assign state    = state_q;
    assign busy     = (state_q == S_HOLDOFF) || (state_q == S_ARMED) || (state_q == S_CAPTURE);
    assign irq_done = (state_q == S_DONE);

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: stimulus pushes expected FIFO writes into a
// scoreboard queue, a negedge monitor pops and compares each write including its cycle.
module tb_adc_capture_sequencer;

    localparam int FRAME_W = 96;
    localparam int CNT_W   = 32;
    localparam int HOLD_W  = 16;

    logic               clk = 1'b0;
    logic               async_resetn;
    logic               ctrl_start, ctrl_abort;
    logic [CNT_W-1:0]   cfg_frame_count;
    logic [1:0]         cfg_trig_mode;
    logic [2:0]         cfg_trig_channel;
    logic [11:0]        cfg_trig_level;
    logic [HOLD_W-1:0]  cfg_holdoff;
    logic               ext_trig, frame_valid, fifo_full;
    logic [FRAME_W-1:0] frame_data;
    logic               fifo_wr_en, busy, irq_done;
    logic [FRAME_W-1:0] fifo_din;
    logic [2:0]         state;
    logic [CNT_W-1:0]   frames_written, frames_dropped;

    adc_capture_sequencer #(.FRAME_W(FRAME_W), .CNT_W(CNT_W), .HOLD_W(HOLD_W)) dut (
        .clk(clk), .async_resetn(async_resetn),
        .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
        .cfg_frame_count(cfg_frame_count), .cfg_trig_mode(cfg_trig_mode),
        .cfg_trig_channel(cfg_trig_channel), .cfg_trig_level(cfg_trig_level),
        .cfg_holdoff(cfg_holdoff), .ext_trig(ext_trig),
        .frame_valid(frame_valid), .frame_data(frame_data), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .busy(busy), .irq_done(irq_done),
        .state(state), .frames_written(frames_written), .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FRAME_W-1:0] data;
        int                 cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [FRAME_W-1:0] actual,
                         input logic [FRAME_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (async_resetn === 1'b1 && fifo_wr_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h expected=no_write", fifo_din);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("fifo_din", fifo_din, e.data);
                check("write_cycle", FRAME_W'(cyc), FRAME_W'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FRAME_W-1:0] mk_frame(input int ch, input logic [11:0] val,
                                                    input logic [7:0] tag);
        logic [FRAME_W-1:0] f;
        for (int k = 0; k < 8; k++) f[12*k +: 12] = (k == ch) ? val : 12'(tag) + 12'(k);
        return f;
    endfunction

    task automatic send_frame(input logic [FRAME_W-1:0] d, input logic full, input logic expect_wr);
        frame_valid = 1'b1;
        frame_data  = d;
        fifo_full   = full;
        if (expect_wr) sb_q.push_back('{data: d, cyc: cyc + 1});
        tick();
        frame_valid = 1'b0;
        fifo_full   = 1'b0;
    endtask

    // After the start edge the cfg inputs are scrambled; the latched copy must be unaffected.
    task automatic start(input logic [CNT_W-1:0] cnt, input logic [1:0] mode, input logic [2:0] ch,
                         input logic [11:0] lvl, input logic [HOLD_W-1:0] hold);
        cfg_frame_count  = cnt;
        cfg_trig_mode    = mode;
        cfg_trig_channel = ch;
        cfg_trig_level   = lvl;
        cfg_holdoff      = hold;
        ctrl_start       = 1'b1;
        tick();
        ctrl_start       = 1'b0;
        cfg_frame_count  = 32'd5;
        cfg_trig_mode    = ~mode;
        cfg_trig_channel = ch + 3'd3;
        cfg_trig_level   = ~lvl;
        cfg_holdoff      = 16'd100;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (state !== s && n < budget) begin
            tick();
            n++;
        end
        check(name, FRAME_W'(state), FRAME_W'(s));
    endtask

    task automatic abort();
        ctrl_abort = 1'b1;
        tick();
        ctrl_abort = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        async_resetn = 1'b0;
        ctrl_start = 0; ctrl_abort = 0; ext_trig = 0; frame_valid = 0; fifo_full = 0;
        frame_data = '0; cfg_frame_count = '0; cfg_trig_mode = '0; cfg_trig_channel = '0;
        cfg_trig_level = '0; cfg_holdoff = '0;
        repeat (3) tick();
        async_resetn = 1'b1;
        tick();

        check("rst_state", FRAME_W'(state), 0);
        check("rst_wr_en", FRAME_W'(fifo_wr_en), 0);
        check("rst_busy", FRAME_W'(busy), 0);
        check("rst_irq", FRAME_W'(irq_done), 0);
        check("rst_din", fifo_din, 0);
        check("rst_written", FRAME_W'(frames_written), 0);
        check("rst_dropped", FRAME_W'(frames_dropped), 0);

        // Mode 0, count 4, holdoff 3, a frame every 5 cycles; a frame in HOLDOFF is ignored.
        start(32'd4, 2'd0, 3'd0, 12'h0, 16'd3);
        check("t1_busy", FRAME_W'(busy), 1);
        n = 0;
        while (state == 3'd1 && n < 20) begin
            n++;
            frame_valid = (n == 2);
            frame_data  = mk_frame(0, 12'hABC, 8'h11);
            tick();
        end
        frame_valid = 1'b0;
        check("t1_holdoff_cycles", FRAME_W'(n), 4);
        check("t1_armed", FRAME_W'(state), 2);
        for (int i = 0; i < 4; i++) begin
            send_frame(mk_frame(0, 12'h100 + 12'(i), 8'h20 + 8'(i)), 1'b0, 1'b1);
            if (i < 3) repeat (4) tick();
        end
        check("t1_done_state", FRAME_W'(state), 4);
        check("t1_irq_high", FRAME_W'(irq_done), 1);
        check("t1_busy_done", FRAME_W'(busy), 0);
        tick();
        check("t1_idle", FRAME_W'(state), 0);
        check("t1_irq_low", FRAME_W'(irq_done), 0);
        check("t1_written", FRAME_W'(frames_written), 4);
        check("t1_dropped", FRAME_W'(frames_dropped), 0);
        send_frame(mk_frame(0, 12'h555, 8'h30), 1'b0, 1'b0);

        // Mode 2 falling, count 1: trigger frame is also the last slot.
        start(32'd1, 2'd2, 3'd2, 12'h800, 16'd0);
        wait_state(3'd2, 10, "t2f_armed");
        send_frame(mk_frame(2, 12'h900, 8'h40), 1'b0, 1'b0);
        check("t2f_no_trig_first", FRAME_W'(state), 2);
        send_frame(mk_frame(2, 12'h7FF, 8'h41), 1'b0, 1'b1);
        check("t2f_done", FRAME_W'(state), 4);
        tick();

        // Mode 1: a lone 0x900 right after arming must not trigger (stale prev cleared in HOLDOFF).
        start(32'd1, 2'd1, 3'd2, 12'h800, 16'd0);
        wait_state(3'd2, 10, "t2a_armed");
        send_frame(mk_frame(2, 12'h900, 8'h50), 1'b0, 1'b0);
        check("t2a_still_armed", FRAME_W'(state), 2);
        check("t2a_written", FRAME_W'(frames_written), 0);
        abort();

        // Mode 1 rising, ch2, level 0x800: triggers on 0x800.
        start(32'd2, 2'd1, 3'd2, 12'h800, 16'd0);
        wait_state(3'd2, 10, "t2b_armed");
        send_frame(mk_frame(2, 12'h7F0, 8'h60), 1'b0, 1'b0);
        send_frame(mk_frame(2, 12'h7FF, 8'h61), 1'b0, 1'b0);
        check("t2b_armed_before_cross", FRAME_W'(state), 2);
        send_frame(mk_frame(2, 12'h800, 8'h62), 1'b0, 1'b1);
        check("t2b_capture", FRAME_W'(state), 3);
        check("t2b_din_ch2", FRAME_W'(fifo_din[35:24]), FRAME_W'(12'h800));
        send_frame(mk_frame(2, 12'h900, 8'h63), 1'b0, 1'b1);
        check("t2b_done", FRAME_W'(state), 4);
        tick();

        // Mode 0, count 6, back-to-back frames, FIFO full for frames 3 and 4.
        start(32'd6, 2'd0, 3'd0, 12'h0, 16'd0);
        wait_state(3'd2, 10, "t3_armed");
        for (int i = 1; i <= 6; i++) begin
            send_frame(mk_frame(1, 12'h200 + 12'(i), 8'h70 + 8'(i)), (i == 3 || i == 4), !(i == 3 || i == 4));
            if (i == 5) check("t3_capture_at_5", FRAME_W'(state), 3);
        end
        check("t3_done", FRAME_W'(state), 4);
        check("t3_written", FRAME_W'(frames_written), 4);
        check("t3_dropped", FRAME_W'(frames_dropped), 2);
        tick();

        // Continuous mode, 10 frames, then abort together with frame_valid.
        start(32'd0, 2'd0, 3'd0, 12'h0, 16'd0);
        wait_state(3'd2, 10, "t4_armed");
        for (int i = 0; i < 10; i++) send_frame(mk_frame(3, 12'h300 + 12'(i), 8'h80 + 8'(i)), 1'b0, 1'b1);
        check("t4_still_capture", FRAME_W'(state), 3);
        ctrl_abort  = 1'b1;
        frame_valid = 1'b1;
        frame_data  = mk_frame(3, 12'hFFF, 8'h90);
        tick();
        ctrl_abort  = 1'b0;
        frame_valid = 1'b0;
        check("t4_idle", FRAME_W'(state), 0);
        check("t4_irq", FRAME_W'(irq_done), 0);
        check("t4_written", FRAME_W'(frames_written), 10);
        tick();
        check("t4_irq_after", FRAME_W'(irq_done), 0);
        check("t4_written_hold", FRAME_W'(frames_written), 10);
        ctrl_start = 1'b1;
        ctrl_abort = 1'b1;
        tick();
        ctrl_start = 1'b0;
        ctrl_abort = 1'b0;
        check("t4_abort_beats_start", FRAME_W'(state), 0);

        // Mode 3: ext_trig low for 5 frames, then high; starts ignored in CAPTURE and DONE.
        start(32'd3, 2'd3, 3'd0, 12'h0, 16'd2);
        wait_state(3'd2, 10, "t5_armed");
        ext_trig = 1'b0;
        for (int i = 0; i < 5; i++) send_frame(mk_frame(4, 12'h400 + 12'(i), 8'hA0 + 8'(i)), 1'b0, 1'b0);
        check("t5_armed_no_ext", FRAME_W'(state), 2);
        ext_trig = 1'b1;
        send_frame(mk_frame(4, 12'h4AA, 8'hB0), 1'b0, 1'b1);
        ext_trig = 1'b0;
        check("t5_capture", FRAME_W'(state), 3);
        check("t5_written_1", FRAME_W'(frames_written), 1);
        cfg_frame_count = 32'd0;
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        check("t5_start_ignored_state", FRAME_W'(state), 3);
        check("t5_start_ignored_cnt", FRAME_W'(frames_written), 1);
        send_frame(mk_frame(4, 12'h4BB, 8'hB1), 1'b0, 1'b1);
        send_frame(mk_frame(4, 12'h4CC, 8'hB2), 1'b0, 1'b1);
        check("t5_done", FRAME_W'(state), 4);
        check("t5_written_3", FRAME_W'(frames_written), 3);
        ctrl_start = 1'b1;
        tick();
        ctrl_start = 1'b0;
        check("t5_start_in_done_ignored", FRAME_W'(state), 0);

        // Async reset mid-capture with a write in flight.
        start(32'd0, 2'd0, 3'd0, 12'h0, 16'd0);
        wait_state(3'd2, 10, "t6_armed");
        send_frame(mk_frame(5, 12'h500, 8'hC0), 1'b0, 1'b1);
        send_frame(mk_frame(5, 12'h501, 8'hC1), 1'b0, 1'b1);
        send_frame(mk_frame(5, 12'h502, 8'hC2), 1'b0, 1'b0);
        check("t6_wr_before_rst", FRAME_W'(fifo_wr_en), 1);
        frame_valid = 1'b1;
        #2;
        async_resetn = 1'b0;
        #1;
        check("t6_rst_wr_en", FRAME_W'(fifo_wr_en), 0);
        check("t6_rst_state", FRAME_W'(state), 0);
        check("t6_rst_busy", FRAME_W'(busy), 0);
        check("t6_rst_din", fifo_din, 0);
        check("t6_rst_written", FRAME_W'(frames_written), 0);
        tick();
        frame_valid = 1'b0;
        tick();
        async_resetn = 1'b1;
        tick();
        start(32'd1, 2'd0, 3'd0, 12'h0, 16'd0);
        wait_state(3'd2, 10, "t6_rearmed");
        send_frame(mk_frame(6, 12'h600, 8'hD0), 1'b0, 1'b1);
        check("t6_done", FRAME_W'(state), 4);
        check("t6_written", FRAME_W'(frames_written), 1);
        repeat (3) tick();

        check("sb_empty", FRAME_W'(sb_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
